fft_addr_gen: RTL
=================

Name: fft_addr_gen

Overview:
- Control and address generator for the shared-butterfly radix-2 in-place FFT. Sits directly upstream of the twiddle generator.
- Walks all log2(N) stages × N/2 butterflies and emits, per butterfly:
  - the two data-memory addresses (A, B);
  - the twiddle index k, which drives the twiddle generator's k input.
- Inserts a drain gap between stages so butterfly write-back finishes before the next stage reads (in-place RAW hazard).
- Decimation-in-time ordering; input data is in bit-reversed order in memory.

Parameters:
- N, 8192, FFT length, power of two, ≥ 4.
- BF_LATENCY, 8, cycles from an accepted butterfly issue to its write-back into memory; must be ≥ 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a full transform; honoured only in IDLE.
- out_ready  input  1  downstream accepts the current butterfly issue.
- out_valid  output  1  addr_a, addr_b, k, stage, last_bf are valid.
- addr_a  output  $clog2(N)  top/even data address.
- addr_b  output  $clog2(N)  bottom/odd data address.
- k  output  $clog2(N/2)  twiddle index into the twiddle generator.
- stage  output  $clog2($clog2(N))  current stage index s, 0..log2(N)-1.
- last_bf  output  1  current issue is the final butterfly of the stage.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the final stage has drained.

Behaviour:
- Reset (asynchronous, on rst high):
  - state = IDLE; stage counter, butterfly counter j, and drain counter = 0.
  - All outputs = 0.
- State registers: state, stage counter s, butterfly counter j (width $clog2(N/2)), drain counter.
- All outputs are combinational decodes of these registers only; there is no combinational path from inputs to outputs.
- Address and twiddle decode, with L = log2(N):
  - addr_a = ((j >> s) << (s+1)) | (j & (2^s − 1)), i.e. a 0 bit inserted at bit position s of j.
  - addr_b = addr_a + 2^s.
  - k = (j & (2^s − 1)) << (L − 1 − s), truncated to $clog2(N/2) bits.
  - last_bf = (j == N/2 − 1) while in RUN.
- FSM:
  - IDLE:
    - out_valid = 0, busy = 0.
    - start = 1 → RUN, with s = 0 and j = 0.
    - First out_valid appears the cycle after start is sampled.
  - RUN:
    - out_valid = 1.
    - A handshake occurs when out_valid & out_ready.
    - While out_ready = 0, hold all outputs stable (no advance).
    - On handshake with j < N/2 − 1: j ← j + 1.
    - On handshake with j = N/2 − 1: j ← 0, drain counter ← BF_LATENCY, go to DRAIN.
  - DRAIN:
    - out_valid = 0.
    - Drain counter decrements every cycle; out_ready is ignored.
    - When the counter reaches 1 (exactly BF_LATENCY cycles spent in DRAIN):
      - if s < L − 1: s ← s + 1, go to RUN;
      - otherwise go to DONE.
  - DONE:
    - done = 1 and out_valid = 0 for exactly one cycle.
    - Clear s to 0, go to IDLE.
- Boundary rules:
  - start while busy: ignored; no restart and no effect on counters.
  - start in the same cycle DONE → IDLE: ignored. A new start is honoured only when sampled in IDLE.
  - j wraps only through the DRAIN transition and never skips a value.
  - Reset mid-transform aborts immediately. There is no partial-done pulse; the next start runs a full transform from s = 0.
  - Stage 0 always produces k = 0. Stage L−1 produces k = j.
- Throughput: with out_ready held high, a transform takes L·(N/2 + BF_LATENCY) cycles from RUN entry to the last DRAIN cycle, plus 1 cycle for DONE.

Test Plan:
- N=16, BF_LATENCY=4, rst asserted mid-RUN at stage 2 → all outputs 0 asynchronously. After release, a start runs a full transform beginning at s=0, j=0: addr_a=0, addr_b=1, k=0.
- N=16, out_ready=1, stage 1, j=3 → addr_a=5, addr_b=7, k=4. Stage 3, j=5 → addr_a=5, addr_b=13, k=5.
- N=16, BF_LATENCY=4, out_ready=1, start sampled at edge 0:
  - out_valid high in cycles 1–8, low in cycles 9–12, high again in cycles 13–20;
  - done pulse in cycle 49;
  - exactly 32 handshakes total;
  - last_bf high on 4 of them.
- Random out_ready stalls (~50% duty) → outputs stable while stalled. The handshake sequence is identical to the unstalled run, with no skipped or duplicated (stage, j) pairs.
- start pulsed during RUN and during DRAIN → no effect on the sequence. start in the cycle after done → new transform begins and repeats the same address sequence.
- N=8192, BF_LATENCY=8, full run with a scoreboard:
  - every address 0..8191 appears exactly once per stage as either addr_a or addr_b;
  - stage 12, j=4095 gives k=4095;
  - done arrives 13·(4096+8)+1 cycles after start.

Source files
------------

// File: rtl/fft_addr_gen.sv
// Control and address generator for a shared-butterfly radix-2 in-place DIT FFT.
// Walks every stage and butterfly, emitting data addresses, twiddle index and stage timing.
module fft_addr_gen #(
    parameter int N          = 8192,
    parameter int BF_LATENCY = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [$clog2(N)-1:0]         addr_a,
    output logic [$clog2(N)-1:0]         addr_b,
    output logic [$clog2(N/2)-1:0]       k,
    output logic [$clog2($clog2(N))-1:0] stage,
    output logic                         last_bf,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = $clog2(N);
    localparam int JW = $clog2(N/2);
    localparam int SW = $clog2(AW);
    localparam int DW = $clog2(BF_LATENCY + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [JW-1:0] J_LAST     = {JW{1'b1}};
    localparam logic [SW-1:0] S_LAST     = SW'(AW - 1);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(BF_LATENCY);
    localparam logic [AW-1:0] ONE_A      = AW'(1'b1);

    logic [1:0]    state_r, state_s;
    logic [SW-1:0] stage_r, stage_s;
    logic [JW-1:0] j_r, j_s;
    logic [DW-1:0] drain_r, drain_s;

    logic [AW-1:0] addr_a_s;
    logic [JW-1:0] k_s;

    // Top address: j with a zero bit inserted at position s.
    function automatic logic [AW-1:0] insert_zero(input logic [JW-1:0] j, input logic [SW-1:0] s);
        logic [AW-1:0] jx;
        logic [AW-1:0] low_mask;
        jx       = {1'b0, j};
        low_mask = (ONE_A << s) - ONE_A;
        return (((jx >> s) << 1'b1) << s) | (jx & low_mask);
    endfunction

    // Twiddle index: the in-group position scaled up to the N/2 twiddle grid.
    function automatic logic [JW-1:0] twiddle_index(input logic [JW-1:0] j, input logic [SW-1:0] s);
        logic [AW-1:0] jx;
        logic [AW-1:0] low_mask;
        logic [AW-1:0] scaled;
        jx       = {1'b0, j};
        low_mask = (ONE_A << s) - ONE_A;
        scaled   = (jx & low_mask) << (S_LAST - s);
        return scaled[JW-1:0];
    endfunction

    // Next-state logic for the stage/butterfly/drain walk.
    always_comb begin
        state_s = state_r;
        stage_s = stage_r;
        j_s     = j_r;
        drain_s = drain_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    stage_s = '0;
                    j_s     = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    if (j_r == J_LAST) begin
                        j_s     = '0;
                        drain_s = DRAIN_LOAD;
                        state_s = ST_DRAIN;
                    end else begin
                        j_s = j_r + JW'(1'b1);
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                drain_s = drain_r - DW'(1'b1);
                // Leave after the last write-back of the stage has landed.
                if (drain_r <= DW'(1'b1)) begin
                    drain_s = '0;
                    if (stage_r == S_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        stage_s = stage_r + SW'(1'b1);
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                stage_s = '0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                stage_s = '0;
                j_s     = '0;
                drain_s = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            stage_r <= '0;
            j_r     <= '0;
            drain_r <= '0;
        end else begin
            state_r <= state_s;
            stage_r <= stage_s;
            j_r     <= j_s;
            drain_r <= drain_s;
        end
    end

    // Address and twiddle decode of the current (stage, j).
    always_comb begin
        addr_a_s = insert_zero(j_r, stage_r);
        k_s      = twiddle_index(j_r, stage_r);
    end

    // Output decode; issue fields read zero whenever no butterfly is presented.
    always_comb begin
        out_valid = (state_r == ST_RUN);
        busy      = (state_r != ST_IDLE);
        done      = (state_r == ST_DONE);
        if (state_r == ST_RUN) begin
            addr_a  = addr_a_s;
            addr_b  = addr_a_s + (ONE_A << stage_r);
            k       = k_s;
            stage   = stage_r;
            last_bf = (j_r == J_LAST);
        end else begin
            addr_a  = '0;
            addr_b  = '0;
            k       = '0;
            stage   = '0;
            last_bf = 1'b0;
        end
    end

endmodule
